// File: rtl/ttc_irq_arbiter30.sv
// Interrupt arbiter for the three TTC counters: picks one pending source,
// presents its ID/status to the CPU and pulses that counter's clear on acknowledge.
module ttc_irq_arbiter30 #(
  parameter int SETTLE_CYC = 2
) (
  input  logic        pclk30,
  input  logic        n_p_reset30,
  input  logic [2:0]  irq_in30,
  input  logic [17:0] irq_stat30,
  input  logic        cfg_sel30,
  input  logic [4:0]  pwdata30,
  input  logic        cpu_ack30,
  output logic        irq_out30,
  output logic [1:0]  irq_id30,
  output logic [5:0]  irq_status_out30,
  output logic [2:0]  clear_interrupt30,
  output logic [3:0]  cfg_out30,
  output logic        overrun30
);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_CLEAR, ST_SETTLE} state_t;

  localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t      r_state;
  logic [1:0]  r_last;
  logic [1:0]  r_id;
  logic [5:0]  r_status;
  logic        r_irqOut;
  logic [2:0]  r_clear;
  logic [3:0]  r_settleCnt;
  logic        r_mode;
  logic [2:0]  r_mask;
  logic [2:0]  r_irqPrev;
  logic        r_overrun;

  logic [2:0]  w_elig;
  logic [1:0]  w_start;
  logic [1:0]  w_winner;
  logic [5:0]  w_winStat;
  logic [2:0]  w_grantOneHot;
  logic [2:0]  w_rise;

  assign w_elig        = irq_in30 & ~r_mask;
  assign w_grantOneHot = 3'b001 << r_id;
  assign w_rise        = irq_in30 & ~r_irqPrev & ~r_mask & ~w_grantOneHot;

  // Fixed mode always starts the search at source 0; round-robin starts after the last grant.
  always_comb begin
    w_start = 2'd0;
    if (r_mode) begin
      w_start = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    end
  end

  always_comb begin
    w_winner = 2'd0;
    case (w_start)
      2'd1: begin
        if (w_elig[1])      w_winner = 2'd1;
        else if (w_elig[2]) w_winner = 2'd2;
        else                w_winner = 2'd0;
      end
      2'd2: begin
        if (w_elig[2])      w_winner = 2'd2;
        else if (w_elig[0]) w_winner = 2'd0;
        else                w_winner = 2'd1;
      end
      default: begin
        if (w_elig[0])      w_winner = 2'd0;
        else if (w_elig[1]) w_winner = 2'd1;
        else                w_winner = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_winStat = 6'd0;
    case (w_winner)
      2'd0:    w_winStat = irq_stat30[5:0];
      2'd1:    w_winStat = irq_stat30[11:6];
      default: w_winStat = irq_stat30[17:12];
    endcase
  end

  always_ff @(posedge pclk30 or negedge n_p_reset30) begin
    if (!n_p_reset30) begin
      r_state     <= ST_IDLE;
      r_last      <= 2'd2;
      r_id        <= 2'd3;
      r_status    <= 6'd0;
      r_irqOut    <= 1'b0;
      r_clear     <= 3'b000;
      r_settleCnt <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_elig) begin
            r_id     <= w_winner;
            r_status <= w_winStat;
            r_irqOut <= 1'b1;
            r_last   <= w_winner;
            r_state  <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (cpu_ack30) begin
            r_clear  <= w_grantOneHot;
            r_irqOut <= 1'b0;
            r_id     <= 2'd3;
            r_status <= 6'd0;
            r_state  <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_clear     <= 3'b000;
          r_settleCnt <= 4'd0;
          r_state     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_settleCnt == LP_SETTLE_LAST) begin
            r_settleCnt <= 4'd0;
            r_state     <= ST_IDLE;
          end else begin
            r_settleCnt <= r_settleCnt + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Config only lands in registers, so the current grant is never disturbed.
  always_ff @(posedge pclk30 or negedge n_p_reset30) begin
    if (!n_p_reset30) begin
      r_mode    <= 1'b0;
      r_mask    <= 3'b000;
      r_irqPrev <= 3'b000;
    end else begin
      r_irqPrev <= irq_in30;
      if (cfg_sel30) begin
        r_mode <= pwdata30[0];
        r_mask <= pwdata30[3:1];
      end
    end
  end

  // A new rising source during presentation wins over a simultaneous clear request.
  always_ff @(posedge pclk30 or negedge n_p_reset30) begin
    if (!n_p_reset30) begin
      r_overrun <= 1'b0;
    end else if (r_state == ST_PRESENT && |w_rise) begin
      r_overrun <= 1'b1;
    end else if (cfg_sel30 && pwdata30[4]) begin
      r_overrun <= 1'b0;
    end
  end

  assign irq_out30         = r_irqOut;
  assign irq_id30          = r_id;
  assign irq_status_out30  = r_status;
  assign clear_interrupt30 = r_clear;
  assign cfg_out30         = {r_mask, r_mode};
  assign overrun30         = r_overrun;

endmodule

// File: tb/tb_ttc_irq_arbiter30.sv
// Randomized bench for ttc_irq_arbiter30 with a transaction-level arbitration model.
module tb_ttc_irq_arbiter30;

  localparam int SETTLE = 2;

  logic        pclk30 = 1'b0;
  logic        n_p_reset30 = 1'b0;
  logic [2:0]  irq_in30 = '0;
  logic [17:0] irq_stat30 = '0;
  logic        cfg_sel30 = 1'b0;
  logic [4:0]  pwdata30 = '0;
  logic        cpu_ack30 = 1'b0;
  logic        irq_out30;
  logic [1:0]  irq_id30;
  logic [5:0]  irq_status_out30;
  logic [2:0]  clear_interrupt30;
  logic [3:0]  cfg_out30;
  logic        overrun30;

  int checks = 0;
  int errors = 0;

  int         mLast = 2;
  bit         mMode = 1'b0;
  logic [2:0] mMask = 3'b000;

  ttc_irq_arbiter30 #(.SETTLE_CYC(SETTLE)) dut (
    .pclk30(pclk30), .n_p_reset30(n_p_reset30), .irq_in30(irq_in30),
    .irq_stat30(irq_stat30), .cfg_sel30(cfg_sel30), .pwdata30(pwdata30),
    .cpu_ack30(cpu_ack30), .irq_out30(irq_out30), .irq_id30(irq_id30),
    .irq_status_out30(irq_status_out30), .clear_interrupt30(clear_interrupt30),
    .cfg_out30(cfg_out30), .overrun30(overrun30)
  );

  always #5 pclk30 = ~pclk30;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Winner = first eligible source scanning from the start point, modulo 3.
  function automatic int modelArb(input logic [2:0] irq);
    logic [2:0] elig;
    int start;
    int idx;
    elig  = irq & ~mMask;
    start = mMode ? (mLast + 1) % 3 : 0;
    for (int k = 0; k < 3; k++) begin
      idx = (start + k) % 3;
      if (elig[idx[1:0]]) return idx;
    end
    return 3;
  endfunction

  task automatic step();
    @(posedge pclk30);
    #1;
  endtask

  task automatic doReset();
    n_p_reset30 = 1'b0;
    irq_in30 = '0; irq_stat30 = '0; cfg_sel30 = 1'b0; pwdata30 = '0; cpu_ack30 = 1'b0;
    repeat (2) step();
    n_p_reset30 = 1'b1;
    mLast = 2; mMode = 1'b0; mMask = 3'b000;
  endtask

  task automatic cfgWrite(input bit mode, input logic [2:0] mask, input bit clrOv);
    cfg_sel30 = 1'b1;
    pwdata30 = {clrOv, mask, mode};
    step();
    cfg_sel30 = 1'b0;
    pwdata30 = '0;
    mMode = mode; mMask = mask;
    checks++;
    if (cfg_out30 !== {mask, mode}) begin
      errors++;
      $display("[TB] FAIL cfg_out: got %b expected %b", cfg_out30, {mask, mode});
    end
  endtask

  task automatic grantStep(input string tag, output int expId, output logic [5:0] expStat);
    logic [17:0] sh;
    expId = modelArb(irq_in30);
    sh = irq_stat30 >> (6 * ((expId == 3) ? 0 : expId));
    expStat = (expId == 3) ? 6'd0 : sh[5:0];
    step();
    checks++;
    if (expId == 3) begin
      if (irq_out30 !== 1'b0 || irq_id30 !== 2'd3) begin
        errors++;
        $display("[TB] FAIL %s no-grant: got out=%b id=%0d expected out=0 id=3", tag, irq_out30, irq_id30);
      end
    end else begin
      mLast = expId;
      if (irq_out30 !== 1'b1 || irq_id30 !== 2'(expId) || irq_status_out30 !== expStat) begin
        errors++;
        $display("[TB] FAIL %s grant: got out=%b id=%0d stat=%h expected out=1 id=%0d stat=%h",
                 tag, irq_out30, irq_id30, irq_status_out30, expId, expStat);
      end
    end
  endtask

  task automatic ackAndSettle(input int id, input logic [5:0] stat, input int delay);
    repeat (delay) step();
    checks++;
    if (irq_out30 !== 1'b1 || irq_id30 !== 2'(id) || irq_status_out30 !== stat) begin
      errors++;
      $display("[TB] FAIL hold: got out=%b id=%0d stat=%h expected out=1 id=%0d stat=%h",
               irq_out30, irq_id30, irq_status_out30, id, stat);
    end
    cpu_ack30 = 1'b1;
    step();
    cpu_ack30 = 1'b0;
    checks++;
    if (clear_interrupt30 !== (3'b001 << id) || irq_out30 !== 1'b0 || irq_id30 !== 2'd3 || irq_status_out30 !== 6'd0) begin
      errors++;
      $display("[TB] FAIL clear pulse: got clr=%b out=%b id=%0d stat=%h expected clr=%b out=0 id=3 stat=0",
               clear_interrupt30, irq_out30, irq_id30, irq_status_out30, 3'b001 << id);
    end
    step();
    checks++;
    if (clear_interrupt30 !== 3'b000) begin
      errors++;
      $display("[TB] FAIL clear width: got clr=%b expected 000", clear_interrupt30);
    end
    for (int i = 0; i < SETTLE; i++) begin
      step();
      checks++;
      if ({irq_out30, clear_interrupt30} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL settle %0d: got out=%b clr=%b expected out=0 clr=000", i, irq_out30, clear_interrupt30);
      end
    end
  endtask

  task automatic test_reset();
    n_p_reset30 = 1'b0;
    step();
    checks++;
    if ({irq_out30, irq_id30, irq_status_out30, clear_interrupt30, cfg_out30, overrun30} !== {1'b0, 2'd3, 6'd0, 3'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset values: got out=%b id=%0d stat=%h clr=%b cfg=%b ov=%b", irq_out30, irq_id30,
               irq_status_out30, clear_interrupt30, cfg_out30, overrun30);
    end
    doReset();
  endtask

  task automatic test_basic();
    int id; logic [5:0] st;
    doReset();
    irq_in30 = 3'b010;
    irq_stat30 = {6'h2a, 6'h04, 6'h15};
    grantStep("basic", id, st);
    irq_in30 = 3'b000;
    ackAndSettle(id, st, 2);
  endtask

  task automatic test_fixed_rr();
    int id; logic [5:0] st;
    doReset();
    irq_in30 = 3'b111;
    for (int n = 0; n < 4; n++) begin
      irq_stat30 = 18'($urandom);
      grantStep("fixed", id, st);
      ackAndSettle(id, st, n);
    end
    doReset();
    cfgWrite(1'b1, 3'b000, 1'b0);
    irq_in30 = 3'b111;
    for (int n = 0; n < 4; n++) begin
      irq_stat30 = 18'($urandom);
      grantStep("rr", id, st);
      ackAndSettle(id, st, 1);
    end
  endtask

  task automatic test_mask();
    int id; logic [5:0] st;
    doReset();
    cfgWrite(1'b0, 3'b001, 1'b0);
    irq_in30 = 3'b001;
    repeat (3) step();
    checks++;
    if (irq_out30 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL masked: got out=%b expected 0", irq_out30);
    end
    cfg_sel30 = 1'b1;
    pwdata30 = 5'b00000;
    step();
    cfg_sel30 = 1'b0;
    checks++;
    if (irq_out30 !== 1'b0 || cfg_out30 !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL unmask edge: got out=%b cfg=%b expected out=0 cfg=0000", irq_out30, cfg_out30);
    end
    mMask = 3'b000;
    grantStep("unmask", id, st);
    irq_in30 = 3'b000;
    ackAndSettle(id, st, 0);
  endtask

  task automatic test_overrun();
    int id; logic [5:0] st;
    doReset();
    irq_in30 = 3'b001;
    grantStep("ovr", id, st);
    step();
    checks++;
    if (overrun30 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun early: got %b expected 0", overrun30);
    end
    irq_in30 = 3'b101;
    step();
    checks++;
    if (overrun30 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun set: got %b expected 1", overrun30);
    end
    cfgWrite(1'b0, 3'b000, 1'b1);
    checks++;
    if (overrun30 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun clear: got %b expected 0", overrun30);
    end
    irq_in30 = 3'b001;
    step();
    irq_in30 = 3'b101;
    cfgWrite(1'b0, 3'b000, 1'b1);
    checks++;
    if (overrun30 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun set-wins: got %b expected 1", overrun30);
    end
    irq_in30 = 3'b000;
    ackAndSettle(id, st, 0);
  endtask

  task automatic test_reset_in_clear();
    int id; logic [5:0] st;
    doReset();
    irq_in30 = 3'b010;
    grantStep("rstclr", id, st);
    irq_in30 = 3'b000;
    cpu_ack30 = 1'b1;
    step();
    cpu_ack30 = 1'b0;
    checks++;
    if (clear_interrupt30 !== 3'b010) begin
      errors++;
      $display("[TB] FAIL pre-reset clear: got %b expected 010", clear_interrupt30);
    end
    #2 n_p_reset30 = 1'b0;
    #1;
    checks++;
    if (clear_interrupt30 !== 3'b000 || irq_id30 !== 2'd3 || irq_out30 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async reset: got clr=%b id=%0d out=%b expected clr=000 id=3 out=0",
               clear_interrupt30, irq_id30, irq_out30);
    end
    step();
    n_p_reset30 = 1'b1;
    mLast = 2; mMode = 1'b0; mMask = 3'b000;
    irq_in30 = 3'b100;
    irq_stat30 = 18'($urandom);
    grantStep("post-reset", id, st);
    irq_in30 = 3'b000;
    ackAndSettle(id, st, 0);
  endtask

  task automatic test_ack_ignored();
    int id; logic [5:0] st;
    doReset();
    cpu_ack30 = 1'b1;
    repeat (2) step();
    checks++;
    if (clear_interrupt30 !== 3'b000 || irq_out30 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle ack: got clr=%b out=%b expected clr=000 out=0", clear_interrupt30, irq_out30);
    end
    irq_in30 = 3'b010;
    grantStep("ack-at-grant", id, st);
    cpu_ack30 = 1'b0;
    irq_in30 = 3'b000;
    step();
    checks++;
    if (clear_interrupt30 !== 3'b000 || irq_out30 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ack at grant: got clr=%b out=%b expected clr=000 out=1", clear_interrupt30, irq_out30);
    end
    cpu_ack30 = 1'b1;
    step();
    cpu_ack30 = 1'b0;
    step();
    cpu_ack30 = 1'b1;
    step();
    cpu_ack30 = 1'b0;
    checks++;
    if (clear_interrupt30 !== 3'b000 || irq_id30 !== 2'd3) begin
      errors++;
      $display("[TB] FAIL settle ack: got clr=%b id=%0d expected clr=000 id=3", clear_interrupt30, irq_id30);
    end
    repeat (3) step();
    checks++;
    if (irq_out30 !== 1'b0 || clear_interrupt30 !== 3'b000) begin
      errors++;
      $display("[TB] FAIL after settle ack: got out=%b clr=%b expected out=0 clr=000", irq_out30, clear_interrupt30);
    end
  endtask

  task automatic test_random();
    int id; logic [5:0] st;
    doReset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        irq_in30 = 3'b000;
        cfgWrite(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0);
      end
      irq_in30 = 3'($urandom_range(0, 7));
      irq_stat30 = 18'($urandom);
      grantStep("random", id, st);
      if (id != 3) begin
        if ($urandom_range(0, 1) == 1) irq_in30 = 3'($urandom_range(0, 7));
        ackAndSettle(id, st, $urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_basic();
    test_fixed_rr();
    test_mask();
    test_overrun();
    test_reset_in_clear();
    test_ack_ignored();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
